// File: rtl/router_vc_fifo.sv
// Multi-VC router input buffer: NumVc independent FIFOs of Depth flits, one push and one pop per cycle.
// Optional flit-type protocol checking is built when ROUTER_VC_FIFO_FLIT_CHECK_EN is defined.

module router_vc_fifo_lane #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] Last = PtrW'(Depth - 1);

  logic [Depth-1:0][Width-1:0] mem;
  logic [PtrW-1:0]             head, tail;
  logic [CntW-1:0]             count;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == Last) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      // push-through on a full lane leaves count at Depth
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[head];
  assign empty = (count == '0);
  assign full  = (count == CntW'(Depth));
endmodule

module router_vc_fifo #(
  parameter int BypassEnable = 1,
  parameter int NumVc        = 4,
  parameter int Depth        = 4,
  parameter int Width        = 8,
  localparam int VcW = (NumVc > 1) ? $clog2(NumVc) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [VcW-1:0]   wr_vc,
  input  logic [Width-1:0] data_in,
  input  logic             rd_en,
  input  logic [VcW-1:0]   rd_vc,
  output logic [Width-1:0] data_out,
  output logic [NumVc-1:0] empty,
  output logic [NumVc-1:0] full,
  output logic             credit_valid,
  output logic [VcW-1:0]   credit_vc,
  output logic             flit_err
);
  localparam logic [VcW:0] VcLim = (VcW + 1)'(NumVc);

  logic                        rd_ok, wr_ok, rd_empty, bypass;
  logic [NumVc-1:0]            rd_sel, wr_sel, pop, push;
  logic [NumVc-1:0][Width-1:0] head_flit;

  // out-of-range VC indices behave as no request
  assign rd_ok    = ({1'b0, rd_vc} < VcLim);
  assign wr_ok    = ({1'b0, wr_vc} < VcLim);
  assign rd_empty = rd_ok ? empty[rd_vc] : 1'b1;
  assign bypass   = (BypassEnable != 0) && rd_en && wr_en && rd_ok && wr_ok &&
                    (rd_vc == wr_vc) && rd_empty;

  for (genvar v = 0; v < NumVc; v++) begin : g_vc
    assign rd_sel[v] = rd_en & rd_ok & (rd_vc == VcW'(v));
    assign wr_sel[v] = wr_en & wr_ok & (wr_vc == VcW'(v));
    assign pop[v]    = rd_sel[v] & ~empty[v];
    assign push[v]   = wr_sel[v] & (~full[v] | pop[v]) & ~bypass;

    router_vc_fifo_lane #(.Depth(Depth), .Width(Width)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (data_in),
      .dout  (head_flit[v]),
      .empty (empty[v]),
      .full  (full[v])
    );
  end

  always_comb begin
    data_out = '0;
    if ((BypassEnable != 0) && rd_empty) data_out = data_in;
    else if (rd_ok)                      data_out = head_flit[rd_vc];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_valid <= 1'b0;
      credit_vc    <= '0;
    end else begin
      credit_valid <= (|pop) | bypass;
      if ((|pop) | bypass) credit_vc <= rd_vc;
    end
  end

`ifdef ROUTER_VC_FIFO_FLIT_CHECK_EN
  logic [NumVc-1:0] pkt_open, wr_take;
  logic [1:0]       ftype;
  logic             err_now;

  assign ftype   = data_in[Width-1 -: 2];
  assign wr_take = push | (bypass ? wr_sel : '0);
  // heads need a closed packet, body/tail need an open one
  assign err_now = |(wr_take & (ftype[1] ? pkt_open : ~pkt_open));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_open <= '0;
      flit_err <= 1'b0;
    end else begin
      if (err_now) flit_err <= 1'b1;
      for (int v = 0; v < NumVc; v++) begin
        if (wr_take[v]) begin
          if (ftype == 2'b10)      pkt_open[v] <= 1'b1;
          else if (ftype == 2'b01) pkt_open[v] <= 1'b0;
        end
      end
    end
  end
`else
  assign flit_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_vc_fifo.sv
// Directed bench for router_vc_fifo with a queue-based reference model checked every cycle.
module tb_router_vc_fifo;
  localparam int NV = 4;
  localparam int DP = 4;

  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0] wr_vc = '0, rd_vc = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic [3:0] empty, full;
  logic       credit_valid, flit_err;
  logic [1:0] credit_vc;

  always #5 clk = ~clk;

  router_vc_fifo #(.BypassEnable(1), .NumVc(NV), .Depth(DP), .Width(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_vc(wr_vc), .data_in(data_in),
    .rd_en(rd_en), .rd_vc(rd_vc), .data_out(data_out), .empty(empty), .full(full),
    .credit_valid(credit_valid), .credit_vc(credit_vc), .flit_err(flit_err)
  );

  logic [7:0] q[NV][$];
  bit         m_cv, m_err;
  logic [1:0] m_cvc;
  bit         m_open[NV];
  int         n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int r, w;
    bit popped, pushed, byp;
    if (!rst_n) begin
      for (int i = 0; i < NV; i++) begin
        q[i].delete();
        m_open[i] = 1'b0;
      end
      m_cv = 1'b0; m_cvc = '0; m_err = 1'b0;
    end else begin
      r = int'(rd_vc);
      w = int'(wr_vc);
      byp    = rd_en && wr_en && (r == w) && (q[r].size() == 0);
      popped = rd_en && (q[r].size() > 0);
      pushed = wr_en && !byp && ((q[w].size() < DP) || (popped && r == w));
`ifdef ROUTER_VC_FIFO_FLIT_CHECK_EN
      if (pushed || byp) begin
        if (data_in[7] ? m_open[w] : !m_open[w]) m_err = 1'b1;
        if (data_in[7:6] == 2'b10) m_open[w] = 1'b1;
        if (data_in[7:6] == 2'b01) m_open[w] = 1'b0;
      end
`endif
      if (popped) void'(q[r].pop_front());
      if (pushed) q[w].push_back(data_in);
      m_cv = popped || byp;
      if (m_cv) m_cvc = rd_vc;
    end
  endtask

  task automatic compare();
    logic [3:0] e_empty, e_full;
    for (int i = 0; i < NV; i++) begin
      e_empty[i] = (q[i].size() == 0);
      e_full[i]  = (q[i].size() == DP);
    end
    chk("empty", empty, e_empty);
    chk("full", full, e_full);
    chk("credit_valid", credit_valid, m_cv);
    if (m_cv) chk("credit_vc", credit_vc, m_cvc);
    chk("flit_err", flit_err, m_err);
    if (q[rd_vc].size() == 0) chk("data_out_bypass", data_out, data_in);
    else                      chk("data_out_head", data_out, q[rd_vc][0]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    logic [7:0] fill_v[4];
    logic [7:0] tail_v[4];
    fill_v = '{8'h81, 8'h00, 8'h00, 8'h41};
    tail_v = '{8'h00, 8'h00, 8'h41, 8'h55};

    tick(); tick();
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 4'h0);
    chk("rst_credit", credit_valid, 1'b0);
    chk("rst_err", flit_err, 1'b0);
    data_in = 8'h3C;
    #1 chk("rst_bypass_dout", data_out, 8'h3C);
    rst_n = 1'b1;
    tick();

    // fill VC2, then an overflow push is dropped
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_vc = 2'd2; data_in = fill_v[i];
      tick();
    end
    wr_en = 1'b0;
    chk("vc2_full", full[2], 1'b1);
    wr_en = 1'b1; data_in = 8'h99;
    tick();
    wr_en = 1'b0;
    chk("vc2_full_drop", full[2], 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_vc = 2'd2;
      #1 chk("pop_order", data_out, fill_v[i]);
      tick();
    end
    rd_en = 1'b0;
    chk("vc2_drained", empty[2], 1'b1);

    // push-through on full VC2
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_vc = 2'd2; data_in = fill_v[i];
      tick();
    end
    rd_en = 1'b1; rd_vc = 2'd2; wr_en = 1'b1; wr_vc = 2'd2; data_in = 8'h55;
    #1 chk("thru_head", data_out, 8'h81);
    tick();
    wr_en = 1'b0;
    chk("thru_full", full[2], 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1 chk("thru_order", data_out, tail_v[i]);
      tick();
    end
    rd_en = 1'b0;

    // push VC0 while popping VC1
    wr_en = 1'b1; wr_vc = 2'd1; data_in = 8'h42;
    tick();
    wr_vc = 2'd0; data_in = 8'hA0; rd_en = 1'b1; rd_vc = 2'd1;
    #1 chk("inter_dout", data_out, 8'h42);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("inter_cv", credit_valid, 1'b1);
    chk("inter_cvc", credit_vc, 2'd1);
    chk("inter_empty0", empty[0], 1'b0);

    // bypass on empty VC3
    rd_en = 1'b1; wr_en = 1'b1; rd_vc = 2'd3; wr_vc = 2'd3; data_in = 8'hC1;
    #1 chk("byp_dout", data_out, 8'hC1);
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("byp_empty3", empty[3], 1'b1);
    chk("byp_cv", credit_valid, 1'b1);
    chk("byp_cvc", credit_vc, 2'd3);

    rd_en = 1'b1; rd_vc = 2'd0;
    #1 chk("drain_vc0", data_out, 8'hA0);
    tick();
    rd_en = 1'b0;
    tick();
    chk("idle_cv", credit_valid, 1'b0);

    // reset with a pending pop discards state and credit
    wr_en = 1'b1; wr_vc = 2'd1; data_in = 8'h81;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_vc = 2'd1; rst_n = 1'b0;
    tick();
    rd_en = 1'b0; rst_n = 1'b1;
    chk("midrst_empty", empty, 4'hF);
    chk("midrst_cv", credit_valid, 1'b0);
    tick();

`ifdef ROUTER_VC_FIFO_FLIT_CHECK_EN
    wr_en = 1'b1; wr_vc = 2'd1; data_in = 8'h80;
    tick();
    chk("err_first_head", flit_err, 1'b0);
    tick();
    wr_en = 1'b0;
    chk("err_set", flit_err, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("err_sticky", flit_err, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("err_cleared", flit_err, 1'b0);
`else
    wr_en = 1'b1; wr_vc = 2'd1; data_in = 8'h41;
    tick();
    wr_en = 1'b0;
    chk("err_tied", flit_err, 1'b0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
